// File: rtl/spl_rd_arbiter.sv
// spl_rd_arbiter
//   Shares one SPL read channel between N_REQ requesters. A round-robin
//   arbiter fills a single registered request slot toward SPL. It stamps
//   the requester ID into the top ID_W tag bits, and it routes each response
//   back to the requester named by the echoed ID. Per-requester credit
//   counters limit the number of reads in flight.
//
// Parameters
//   N_REQ      number of requesters (2..4)
//   MAX_OUTST  max reads in flight per requester (1..255)
//   ID_W       requester-ID tag bits, max(1, clog2(N_REQ))
//
// Ports
//   clk, rst                      clock, async active-high reset
//   req_valid/req_data/req_ready  requester side; req_data[i*80+:80] = {tag, addr}
//   resp_valid/resp_data/resp_ready
//                                 response fan-out; resp_data shared, ID bits cleared
//   spl_rd_req_*                  registered request toward SPL
//   spl_rd_resp_*                 response from SPL
//   tag_err                       sticky flag: a response carried ID >= N_REQ
//
// Optional feature macro: SPL_RD_ARB_PERF_EN adds stall_cnt (saturating) and
// grant_cnt (per requester, wrapping) performance counters.

module spl_rd_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MAX_OUTST = 8,
    parameter int ID_W      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*80-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [527:0]         resp_data,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic                 spl_rd_req_valid,
    output logic [79:0]          spl_rd_req_data,
    input  logic                 spl_rd_req_ready,
    input  logic                 spl_rd_resp_valid,
    input  logic [527:0]         spl_rd_resp_data,
    output logic                 spl_rd_resp_ready,
    output logic                 tag_err
`ifdef SPL_RD_ARB_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [N_REQ*32-1:0]  grant_cnt
`endif
);

    localparam int CNT_W = 8;

    logic                          req_vld_q, req_vld_d;
    logic [79:0]                   req_dat_q, req_dat_d;
    logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0][CNT_W-1:0]   outst_q, outst_d;
    logic                          tag_err_q, tag_err_d;

    logic                          load_en;
    logic                          found;
    logic                          grant;
    logic [ID_W-1:0]               win_id;
    logic [N_REQ-1:0]              elig;
    logic [79:0]                   stamped;
    logic [ID_W-1:0]               resp_id;
    logic                          id_ok;
    logic [N_REQ-1:0]              resp_hs;

    // Request side: eligibility, round-robin pick, output slot load.
    always_comb begin
        load_en   = !req_vld_q || spl_rd_req_ready;
        found     = 1'b0;
        win_id    = '0;
        req_vld_d = req_vld_q;
        req_dat_d = req_dat_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        stamped   = '0;

        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
        end

        // Scan starts at rr_ptr and wraps; the first eligible requester wins.
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && elig[(int'(rr_ptr_q) + k) % N_REQ]) begin
                found  = 1'b1;
                win_id = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end

        grant = load_en && found;

        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = grant && (win_id == ID_W'(i));
        end

        stamped             = req_data[int'(win_id)*80 +: 80];
        stamped[79 -: ID_W] = win_id;

        if (load_en) begin
            req_vld_d = grant;
            if (grant) begin
                req_dat_d = stamped;
                rr_ptr_d  = ID_W'((int'(win_id) + 1) % N_REQ);
            end
        end
    end

    // Response side: purely combinational routing on the echoed ID.
    always_comb begin
        resp_id           = spl_rd_resp_data[527 -: ID_W];
        id_ok             = int'(resp_id) < N_REQ;
        resp_data         = spl_rd_resp_data;
        resp_data[527 -: ID_W] = '0;
        resp_valid        = '0;
        resp_hs           = '0;
        // Unknown IDs are sunk so that a bad tag never stalls the channel.
        spl_rd_resp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            if (id_ok && (resp_id == ID_W'(i))) begin
                resp_valid[i]     = spl_rd_resp_valid;
                spl_rd_resp_ready = resp_ready[i];
                resp_hs[i]        = spl_rd_resp_valid && resp_ready[i];
            end
        end
        tag_err_d = tag_err_q || (spl_rd_resp_valid && !id_ok);
    end

    // Credits: a grant and a response for the same requester in one cycle cancel.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            outst_d[i] = outst_q[i];
            case ({req_ready[i], resp_hs[i]})
                2'b10:   outst_d[i] = outst_q[i] + CNT_W'(1);
                2'b01:   outst_d[i] = outst_q[i] - CNT_W'(1);
                default: outst_d[i] = outst_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_vld_q <= 1'b0;
            req_dat_q <= '0;
            rr_ptr_q  <= '0;
            outst_q   <= '0;
            tag_err_q <= 1'b0;
        end else begin
            req_vld_q <= req_vld_d;
            req_dat_q <= req_dat_d;
            rr_ptr_q  <= rr_ptr_d;
            outst_q   <= outst_d;
            tag_err_q <= tag_err_d;
        end
    end

    assign spl_rd_req_valid = req_vld_q;
    assign spl_rd_req_data  = req_dat_q;
    assign tag_err          = tag_err_q;

    for (genvar g = 0; g < N_REQ; g++) begin : g_credit_chk
        credit_underflow: assert property (@(posedge clk) disable iff (rst)
            resp_hs[g] |-> (outst_q[g] != '0));
    end

`ifdef SPL_RD_ARB_PERF_EN
    logic [31:0]              stall_cnt_q, stall_cnt_d;
    logic [N_REQ-1:0][31:0]   grant_cnt_q, grant_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (req_vld_q && !spl_rd_req_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i] + {31'd0, req_ready[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_spl_rd_arbiter.sv
module tb_spl_rd_arbiter;

    localparam int N    = 2;
    localparam int MAXO = 2;

    logic          clk;
    logic          rst;

    // Main instance: N_REQ=2, MAX_OUTST=2
    logic [N-1:0]    req_valid;
    logic [N*80-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [527:0]    resp_data;
    logic [N-1:0]    resp_ready;
    logic            spl_rd_req_valid;
    logic [79:0]     spl_rd_req_data;
    logic            spl_rd_req_ready;
    logic            spl_rd_resp_valid;
    logic [527:0]    spl_rd_resp_data;
    logic            spl_rd_resp_ready;
    logic            tag_err;

    // Second instance: N_REQ=3 (ID_W=2) for unknown-ID handling
    logic [2:0]      req_valid_3;
    logic [239:0]    req_data_3;
    logic [2:0]      req_ready_3;
    logic [2:0]      resp_valid_3;
    logic [527:0]    resp_data_3;
    logic [2:0]      resp_ready_3;
    logic            spl_rd_req_valid_3;
    logic [79:0]     spl_rd_req_data_3;
    logic            spl_rd_req_ready_3;
    logic            spl_rd_resp_valid_3;
    logic [527:0]    spl_rd_resp_data_3;
    logic            spl_rd_resp_ready_3;
    logic            tag_err_3;

    int n_vec;
    int n_err;

    spl_rd_arbiter #(.N_REQ(2), .MAX_OUTST(MAXO), .ID_W(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .spl_rd_req_valid(spl_rd_req_valid), .spl_rd_req_data(spl_rd_req_data),
        .spl_rd_req_ready(spl_rd_req_ready),
        .spl_rd_resp_valid(spl_rd_resp_valid), .spl_rd_resp_data(spl_rd_resp_data),
        .spl_rd_resp_ready(spl_rd_resp_ready),
        .tag_err(tag_err)
    );

    spl_rd_arbiter #(.N_REQ(3), .MAX_OUTST(2), .ID_W(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_3), .req_data(req_data_3), .req_ready(req_ready_3),
        .resp_valid(resp_valid_3), .resp_data(resp_data_3), .resp_ready(resp_ready_3),
        .spl_rd_req_valid(spl_rd_req_valid_3), .spl_rd_req_data(spl_rd_req_data_3),
        .spl_rd_req_ready(spl_rd_req_ready_3),
        .spl_rd_resp_valid(spl_rd_resp_valid_3), .spl_rd_resp_data(spl_rd_resp_data_3),
        .spl_rd_resp_ready(spl_rd_resp_ready_3),
        .tag_err(tag_err_3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model of the main instance. Its state is the content of the
    // one request slot, whose turn it is, and how many reads each requester
    // has in flight. It is evaluated at the falling edge on stable inputs and
    // then stepped to the state after the next rising edge.
    bit          m_vld;
    logic [79:0] m_data;
    int          m_turn;
    int          m_inflight[N];
    int          grants[$];

    always @(negedge clk) begin
        int          winner;
        bit          can_load;
        int          id;
        logic [N-1:0] exp_rr;
        logic [527:0] exp_rd;
        logic [79:0]  r;
        if (rst) begin
            m_vld  = 1'b0;
            m_data = '0;
            m_turn = 0;
            for (int i = 0; i < N; i++) m_inflight[i] = 0;
            grants.delete();
            chk("rst_spl_valid", 528'(spl_rd_req_valid), 528'(0));
            chk("rst_spl_data", 528'(spl_rd_req_data), 528'(0));
            chk("rst_tag_err", 528'(tag_err), 528'(0));
        end else begin
            chk("m_spl_valid", 528'(spl_rd_req_valid), 528'(m_vld));
            if (m_vld) chk("m_spl_data", 528'(spl_rd_req_data), 528'(m_data));

            can_load = !m_vld || spl_rd_req_ready;
            winner   = -1;
            if (can_load) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_turn + k) % N;
                    if (winner < 0 && req_valid[j] && m_inflight[j] < MAXO) winner = j;
                end
            end
            exp_rr = '0;
            if (winner >= 0) exp_rr[winner] = 1'b1;
            chk("m_req_ready", 528'(req_ready), 528'(exp_rr));

            id = int'(spl_rd_resp_data[527]);
            if (spl_rd_resp_valid) begin
                exp_rd      = spl_rd_resp_data;
                exp_rd[527] = 1'b0;
                chk("m_resp_valid", 528'(resp_valid), 528'(1 << id));
                chk("m_resp_data", resp_data, exp_rd);
            end else begin
                chk("m_resp_valid_idle", 528'(resp_valid), 528'(0));
            end
            chk("m_spl_resp_ready", 528'(spl_rd_resp_ready), 528'(resp_ready[id]));
            chk("m_tag_err", 528'(tag_err), 528'(0));

            if (spl_rd_resp_valid && resp_ready[id]) m_inflight[id]--;
            if (can_load) begin
                if (winner >= 0) begin
                    r      = req_data[winner*80 +: 80];
                    r[79]  = winner[0];
                    m_data = r;
                    m_vld  = 1'b1;
                    m_turn = (winner + 1) % N;
                    m_inflight[winner]++;
                    grants.push_back(winner);
                end else begin
                    m_vld = 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one SPL response for a single cycle and check its routing.
    task automatic send_resp(input logic [15:0] tag, input logic [1:0] rdy,
                             input logic [1:0] exp_rv, input logic exp_srdy,
                             input logic [15:0] exp_tag);
        spl_rd_resp_valid = 1'b1;
        spl_rd_resp_data  = {tag, {16{32'hCAFE_0000 | 32'(tag)}}};
        resp_ready        = rdy;
        #1;
        chk("resp_valid_lit", 528'(resp_valid), 528'(exp_rv));
        chk("resp_ready_lit", 528'(spl_rd_resp_ready), 528'(exp_srdy));
        chk("resp_tag_lit", 528'(resp_data[527:512]), 528'(exp_tag));
        cyc();
        spl_rd_resp_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        req_valid = '0; req_data = '0; resp_ready = '0;
        spl_rd_req_ready = 1'b1; spl_rd_resp_valid = 1'b0; spl_rd_resp_data = '0;
        req_valid_3 = '0; req_data_3 = '0; resp_ready_3 = '0;
        spl_rd_req_ready_3 = 1'b1; spl_rd_resp_valid_3 = 1'b0; spl_rd_resp_data_3 = '0;

        repeat (2) cyc();
        chk("reset_valid", 528'(spl_rd_req_valid), 528'(0));
        chk("reset_data", 528'(spl_rd_req_data), 528'(0));
        chk("reset_tag_err3", 528'(tag_err_3), 528'(0));
        rst = 1'b0;
        cyc();

        // Alternating grants and tag stamping
        req_data  = {16'h0005, 64'h2000, 16'h0005, 64'h1000};
        req_valid = 2'b11;
        #1 chk("t1_ready_c0", 528'(req_ready), 528'(2'b01));
        cyc();
        chk("t2_req0_data", 528'(spl_rd_req_data), 528'({16'h0005, 64'h1000}));
        chk("t1_ready_c1", 528'(req_ready), 528'(2'b10));
        cyc();
        chk("t2_req1_data", 528'(spl_rd_req_data), 528'({16'h8005, 64'h2000}));
        chk("t1_ready_c2", 528'(req_ready), 528'(2'b01));
        cyc();
        chk("t1_data_c3", 528'(spl_rd_req_data), 528'({16'h0005, 64'h1000}));
        chk("t1_ready_c3", 528'(req_ready), 528'(2'b10));
        cyc();
        chk("t1_data_c4", 528'(spl_rd_req_data), 528'({16'h8005, 64'h2000}));
        chk("t1_credits_out", 528'(req_ready), 528'(2'b00));
        req_valid = 2'b00;
        cyc();
        chk("t1_drained", 528'(spl_rd_req_valid), 528'(0));
        chk("t1_grant_cnt", 528'(grants.size()), 528'(4));
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("t1_grant_seq", 528'(grants[i]), 528'(i % 2));

        send_resp(16'h0001, 2'b11, 2'b01, 1'b1, 16'h0001);
        send_resp(16'h0002, 2'b11, 2'b01, 1'b1, 16'h0002);
        send_resp(16'h8001, 2'b11, 2'b10, 1'b1, 16'h0001);
        send_resp(16'h8002, 2'b11, 2'b10, 1'b1, 16'h0002);

        // Credit limit
        req_valid = 2'b01;
        #1 chk("t4_r0_g1", 528'(req_ready), 528'(2'b01));
        cyc();
        chk("t4_r0_g2", 528'(req_ready), 528'(2'b01));
        cyc();
        chk("t4_r0_blocked", 528'(req_ready), 528'(2'b00));
        req_valid = 2'b11;
        #1 chk("t4_r1_g1", 528'(req_ready), 528'(2'b10));
        cyc();
        chk("t4_r1_g2", 528'(req_ready), 528'(2'b10));
        cyc();
        spl_rd_resp_valid = 1'b1;
        spl_rd_resp_data  = {16'h0001, 512'h1234};
        resp_ready        = 2'b11;
        #1 chk("t4_resp_cycle", 528'(req_ready), 528'(2'b00));
        cyc();
        spl_rd_resp_valid = 1'b0;
        #1 chk("t4_r0_again", 528'(req_ready), 528'(2'b01));
        cyc();
        req_valid = 2'b00;
        cyc();
        send_resp(16'h0001, 2'b11, 2'b01, 1'b1, 16'h0001);
        send_resp(16'h0002, 2'b11, 2'b01, 1'b1, 16'h0002);
        send_resp(16'h8001, 2'b11, 2'b10, 1'b1, 16'h0001);
        send_resp(16'h8002, 2'b11, 2'b10, 1'b1, 16'h0002);

        // Back-pressure from SPL
        spl_rd_req_ready = 1'b0;
        req_valid = 2'b11;
        #1 chk("t3_load", 528'(req_ready), 528'(2'b10));
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 528'(spl_rd_req_valid), 528'(1));
            chk("t3_hold_data", 528'(spl_rd_req_data), 528'({16'h8005, 64'h2000}));
            chk("t3_hold_ready", 528'(req_ready), 528'(2'b00));
            cyc();
        end
        spl_rd_req_ready = 1'b1;
        #1 chk("t3_release", 528'(req_ready), 528'(2'b01));
        cyc();
        chk("t3_next", 528'(spl_rd_req_data), 528'({16'h0005, 64'h1000}));
        req_valid = 2'b00;
        cyc();

        // Response back-pressure from requester 1
        spl_rd_resp_valid = 1'b1;
        spl_rd_resp_data  = {16'h8003, 512'hBEEF};
        resp_ready        = 2'b01;
        #1;
        chk("t5_rv", 528'(resp_valid), 528'(2'b10));
        chk("t5_stall", 528'(spl_rd_resp_ready), 528'(0));
        cyc();
        chk("t5_rv_hold", 528'(resp_valid), 528'(2'b10));
        resp_ready = 2'b11;
        #1;
        chk("t5_go", 528'(spl_rd_resp_ready), 528'(1));
        chk("t5_tag", 528'(resp_data[527:512]), 528'(16'h0003));
        cyc();
        spl_rd_resp_valid = 1'b0;
        send_resp(16'h0001, 2'b11, 2'b01, 1'b1, 16'h0001);

        // Three-requester instance: stamping ID 2, routing ID 2, sinking ID 3
        req_data_3  = {16'h0005, 64'h3000, 160'd0};
        req_valid_3 = 3'b100;
        #1 chk("t6_r2_grant", 528'(req_ready_3), 528'(3'b100));
        cyc();
        req_valid_3 = 3'b000;
        chk("t6_r2_stamp", 528'(spl_rd_req_data_3), 528'({16'h8005, 64'h3000}));
        spl_rd_resp_valid_3 = 1'b1;
        spl_rd_resp_data_3  = {16'h8004, 512'h77};
        resp_ready_3        = 3'b011;
        #1;
        chk("t6_id2_rv", 528'(resp_valid_3), 528'(3'b100));
        chk("t6_id2_rdy", 528'(spl_rd_resp_ready_3), 528'(0));
        chk("t6_id2_tag", 528'(resp_data_3[527:512]), 528'(16'h0004));
        spl_rd_resp_data_3 = {16'hC007, 512'h99};
        #1;
        chk("t6_sink_rdy", 528'(spl_rd_resp_ready_3), 528'(1));
        chk("t6_sink_rv", 528'(resp_valid_3), 528'(3'b000));
        chk("t6_err_pre", 528'(tag_err_3), 528'(0));
        cyc();
        spl_rd_resp_valid_3 = 1'b0;
        chk("t6_err_set", 528'(tag_err_3), 528'(1));
        repeat (3) cyc();
        chk("t6_err_sticky", 528'(tag_err_3), 528'(1));

        // Asynchronous reset in the middle of a burst
        req_valid = 2'b11;
        cyc();
        cyc();
        chk("t6_burst_valid", 528'(spl_rd_req_valid), 528'(1));
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", 528'(spl_rd_req_valid), 528'(0));
        chk("t6_async_data", 528'(spl_rd_req_data), 528'(0));
        chk("t6_async_err3", 528'(tag_err_3), 528'(0));
        cyc();
        cyc();
        rst = 1'b0;
        req_valid = 2'b00;
        cyc();
        cyc();
        chk("t6_after_rst", 528'(spl_rd_req_valid), 528'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
